// File: rtl/scc_tone_pkg.sv
// Shared defaults for the N-channel SCC tone generator: channel count, widths,
// the wave-error channel mask and the channel-index type.
package scc_tone_pkg;

  localparam int SCC_CH_NUM = 5;
  localparam int SCC_FREQ_W = 12;
  localparam int SCC_ADDR_W = 5;
  localparam int SCC_CH_W   = $clog2(SCC_CH_NUM);

  // Bit n selects channel n for wave-error timing (channels 3 and 4 by default).
  localparam logic [15:0] SCC_ERR_MASK = 16'b0000_0000_0001_1000;

  typedef logic [SCC_CH_W-1:0] scc_ch_t;

endpackage

// File: rtl/scc_slot_sequencer.sv
// Round-robin channel slot counter: advances one slot per enabled cycle and
// wraps from CH_NUM-1 back to 0.
module scc_slot_sequencer #(
  parameter int CH_NUM = 5,
  parameter int CH_W   = $clog2(CH_NUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  output logic [CH_W-1:0] slot_o
);

  logic [CH_W-1:0] slot_q;
  logic [CH_W-1:0] slot_d;

  always_comb begin
    slot_d = slot_q;
    if (enable) begin
      if (slot_q == CH_W'(CH_NUM - 1)) begin
        slot_d = '0;
      end else begin
        slot_d = slot_q + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/scc_tone_generator_nch.sv
// N-channel SCC tone generator: per-channel frequency counters and wave
// addresses, one channel serviced per enabled cycle, outputs registered.
// Optional wave-error strobe masking is built when SCC_TONE_ERROR_TIMING_EN is defined.
module scc_tone_generator_nch
  import scc_tone_pkg::*;
#(
  parameter int          CH_NUM      = SCC_CH_NUM,
  parameter int          FREQ_W      = SCC_FREQ_W,
  parameter int          ADDR_W      = SCC_ADDR_W,
  parameter int          CH_W        = $clog2(CH_NUM),
  parameter logic [15:0] ERR_CH_MASK = SCC_ERR_MASK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              reg_wr,
  input  logic [CH_W-1:0]   reg_ch,
  input  logic [FREQ_W-1:0] reg_freq,
  input  logic              reg_wave_reset,
  input  logic              key_wr,
  input  logic              key_on,
  input  logic              reg_wave_error_en,
  output logic [CH_W-1:0]   out_ch,
  output logic [ADDR_W-1:0] wave_address,
  output logic              wave_update,
  output logic              out_valid
);

  logic [CH_W-1:0]   slot;
  logic [FREQ_W-1:0] freq_q [CH_NUM];
  logic [FREQ_W-1:0] freq_d [CH_NUM];
  logic [FREQ_W-1:0] cnt_q  [CH_NUM];
  logic [FREQ_W-1:0] cnt_d  [CH_NUM];
  logic [ADDR_W-1:0] addr_q [CH_NUM];
  logic [ADDR_W-1:0] addr_d [CH_NUM];
  logic [CH_NUM-1:0] key_q;
  logic [CH_NUM-1:0] key_d;

  logic [FREQ_W-1:0] cur_cnt;
  logic [FREQ_W-1:0] cur_freq;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_key;
  logic              period_end;
  logic              err_block;

  logic [CH_W-1:0]   out_ch_q;
  logic [ADDR_W-1:0] wave_address_q;
  logic              wave_update_q;
  logic              out_valid_q;

  scc_slot_sequencer #(
    .CH_NUM (CH_NUM),
    .CH_W   (CH_W)
  ) u_slot_seq (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .slot_o (slot)
  );

  // ">=" lets a freshly lowered frequency end the period at once.
  always_comb begin
    cur_cnt    = cnt_q[slot];
    cur_freq   = freq_q[slot];
    cur_addr   = addr_q[slot];
    cur_key    = key_q[slot];
    period_end = (cur_cnt >= cur_freq);
  end

  // Slot processing first, then register writes override it for the same channel.
  always_comb begin
    for (int ch = 0; ch < CH_NUM; ch++) begin
      freq_d[ch] = freq_q[ch];
      cnt_d[ch]  = cnt_q[ch];
      addr_d[ch] = addr_q[ch];
      key_d[ch]  = key_q[ch];
      if (enable && key_q[ch] && (slot == CH_W'(ch))) begin
        if (cnt_q[ch] >= freq_q[ch]) begin
          cnt_d[ch]  = '0;
          addr_d[ch] = addr_q[ch] + ADDR_W'(1);
        end else begin
          cnt_d[ch] = cnt_q[ch] + FREQ_W'(1);
        end
      end
      if (reg_wr && (reg_ch == CH_W'(ch))) begin
        freq_d[ch] = reg_freq;
        cnt_d[ch]  = '0;
        if (reg_wave_reset) begin
          addr_d[ch] = '0;
        end
      end
      if (key_wr && (reg_ch == CH_W'(ch))) begin
        key_d[ch] = key_on;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < CH_NUM; ch++) begin
        freq_q[ch] <= '0;
        cnt_q[ch]  <= '0;
        addr_q[ch] <= '0;
      end
      key_q <= '0;
    end else begin
      freq_q <= freq_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      key_q  <= key_d;
    end
  end

`ifdef SCC_TONE_ERROR_TIMING_EN
  logic [4:0] err_q [CH_NUM];
  logic [4:0] err_d [CH_NUM];
  logic [5:0] err_sum;

  // The carry out of the running error sum suppresses the strobe, not the advance.
  always_comb begin
    err_sum   = {1'b0, err_q[slot]} + {1'b0, ~cur_freq[4:0]};
    err_block = ERR_CH_MASK[slot] & reg_wave_error_en & err_sum[5];
    for (int ch = 0; ch < CH_NUM; ch++) begin
      err_d[ch] = err_q[ch];
      if (ERR_CH_MASK[ch] && enable && (slot == CH_W'(ch))) begin
        err_d[ch] = err_sum[4:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < CH_NUM; ch++) begin
        err_q[ch] <= '0;
      end
    end else begin
      err_q <= err_d;
    end
  end
`else
  logic unused_err_cfg;
  assign err_block      = 1'b0;
  assign unused_err_cfg = reg_wave_error_en ^ (|ERR_CH_MASK);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_ch_q       <= '0;
      wave_address_q <= '0;
      wave_update_q  <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      out_valid_q   <= enable;
      wave_update_q <= enable & period_end & cur_key & ~err_block;
      if (enable) begin
        out_ch_q       <= slot;
        wave_address_q <= cur_addr;
      end
    end
  end

  assign out_ch       = out_ch_q;
  assign wave_address = wave_address_q;
  assign wave_update  = wave_update_q;
  assign out_valid    = out_valid_q;

endmodule

// File: doc/scc_tone_generator_nch.md
Name: scc_tone_generator_nch

Overview:
- Parametrised successor of the fixed 5-channel SCC tone generator: N channels, configurable frequency-counter and wave-address widths.
- Contains its own channel-slot sequencer, per-channel frequency registers and key-enable bits, so it no longer depends on an external `active` mux.
- Each serviced slot emits the channel index, that channel's wave RAM address and a wave-update strobe to the wave-memory/mixer stage.

Parameters:
- CH_NUM, 5: number of channels (2..16).
- FREQ_W, 12: frequency register and counter width.
- ADDR_W, 5: wave address width (wave length 2**ADDR_W).
- CH_W, $clog2(CH_NUM): channel index width (derived).
- ERR_CH_MASK, 5'b11000: channels subject to SCC wave-error timing (bit n = channel n).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  slot advance strobe; one channel is serviced per cycle with enable=1.
- reg_wr  in  1  frequency register write strobe.
- reg_ch  in  CH_W  channel addressed by reg_wr / key_wr.
- reg_freq  in  FREQ_W  frequency value written.
- reg_wave_reset  in  1  global mode bit: a frequency write also zeroes that channel's wave address.
- key_wr  in  1  key-enable write strobe.
- key_on  in  1  key-enable value for reg_ch.
- reg_wave_error_en  in  1  enables error timing on ERR_CH_MASK channels.
- out_ch  out  CH_W  channel of the current output slot.
- wave_address  out  ADDR_W  wave address of out_ch before the increment.
- wave_update  out  1  one-cycle strobe: out_ch advanced its address this slot.
- out_valid  out  1  outputs are meaningful this cycle.

Behaviour:
- Reset: slot counter=0; every counter, address, error count and frequency register=0; key bits=0; out_ch=0, wave_address=0, wave_update=0, out_valid=0. Reset asserted mid-operation clears everything on the next clk edge, with no partial slot.
- Slot sequencer: when enable=1, slot increments and wraps CH_NUM-1 to 0. When enable=0, all state holds and out_valid=0 on the next cycle.
- Slot processing for channel s, when enable=1:
  - end = (cnt[s] >= freq[s]). The ">=" is deliberate: a new frequency below the running count ends the period immediately instead of wrapping through 2**FREQ_W.
  - If end: cnt[s] <= 0 and addr[s] <= addr[s]+1, wrapping modulo 2**ADDR_W. Otherwise cnt[s] <= cnt[s]+1.
  - If key[s]=0: cnt[s] and addr[s] hold, and the update strobe is 0.
- Output latency is 1 cycle, all outputs registered. The cycle after slot s is processed: out_ch=s, wave_address=old addr[s], wave_update=end&key[s] (gated by error logic), out_valid=1.
- freq=0: end on every visit, so the address advances once per CH_NUM slots.
- Register write (reg_wr): freq[reg_ch] <= reg_freq and cnt[reg_ch] <= 0. If reg_wave_reset=1, addr[reg_ch] <= 0 as well. A write to reg_ch>=CH_NUM is ignored.
- Write collision: a write to the channel being processed in the same cycle takes priority. The slot counter still advances, the output is produced from pre-write state, and the written values persist.
- key_wr: key[reg_ch] <= key_on. It may coincide with reg_wr, and both take effect.

Optional Feature:
- Macro SCC_TONE_ERROR_TIMING_EN.
- Defined: each ERR_CH_MASK channel keeps a 5-bit err[s], updated on every processed visit as sum = err[s] + ~freq[s][4:0] (6-bit) and err[s] <= sum[4:0]. wave_update is additionally masked by (~reg_wave_error_en | ~sum[5]). The address still advances; only the strobe is suppressed.
- Undefined: err registers are absent, reg_wave_error_en is ignored, and wave_update = end&key.

Decomposition:
- Package scc_tone_pkg holds the default constants (SCC_CH_NUM=5, SCC_FREQ_W=12, SCC_ADDR_W=5, SCC_ERR_MASK) and the channel-index typedef.
- One sub-module, scc_slot_sequencer, contains the slot counter and its wrap/enable logic.
- Per-channel state stays as arrays in the top module.

Test Plan:
- Reset then enable=1, keys off, CH_NUM=5 -> out_ch cycles 0,1,2,3,4,0 from the second cycle; wave_update stays 0; wave_address stays 0.
- Key ch0 on, freq0=2 -> ch0 wave_update on every 3rd ch0 visit; wave_address 0,0,0,1,1,1,2…
- freq1=0, key on, run 32×5 slots -> ch1 address wraps 31 to 0; wave_update every visit.
- cnt2 reaches 10 with freq2=100, then write freq2=3 with reg_wave_reset=1 -> addr2=0, cnt2=0; the next period ends after 4 visits.
- Write to ch3 in the same cycle ch3 is serviced -> output reflects the old addr; the new freq applies from the next visit.
- With SCC_TONE_ERROR_TIMING_EN, reg_wave_error_en=1, freq3=0 -> ~freq[4:0]=31; on each visit the strobe is suppressed when the running sum carries; verify against a reference model over 64 visits. With reg_wave_error_en=0, every end strobes.
